// File: rtl/dct_frame_scheduler.sv
// Frame scheduler for the serial DCT engine: load a frame, replay it into the engine, drain the coefficients.
// Optional macro DCT_SCHED_CLR_EN inserts a one-cycle engine clear (CLR) between LOAD and RUN.
module dct_frame_scheduler #(
  parameter int unsigned DCT_POINT = 16,
  parameter int unsigned M         = 23,
  parameter int unsigned E         = 8,
  parameter int unsigned LATENCY   = 20,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [M+E:0]                 s_data,
  output logic                         eng_en,
  output logic [M+E:0]                 eng_inp,
  input  logic [M+E:0]                 eng_out,
  output logic                         eng_reset,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [M+E:0]                 m_data,
  output logic [$clog2(DCT_POINT)-1:0] m_index,
  output logic                         m_last,
  output logic                         busy,
  output logic [CNT_W-1:0]             frame_count
);

  localparam int unsigned W     = M + E + 1;
  localparam int unsigned IDX_W = $clog2(DCT_POINT);
  localparam int unsigned T_W   = $clog2(LATENCY + DCT_POINT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_POINT - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(LATENCY + DCT_POINT - 1);
  localparam logic [T_W-1:0]   T_LAT    = T_W'(LATENCY);
  localparam logic [T_W-1:0]   T_PTS    = T_W'(DCT_POINT);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLR   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] w_wr_next;
  logic [T_W-1:0]   r_t;
  logic [T_W-1:0]   w_t_next;
  logic [IDX_W-1:0] r_rd_idx;
  logic [IDX_W-1:0] w_rd_next;
  logic             w_frame_done;

  logic [W-1:0]     r_in_buf  [DCT_POINT];
  logic [W-1:0]     r_out_buf [DCT_POINT];

  logic             r_s_ready;
  logic             r_busy;
  logic             r_eng_en;
  logic [W-1:0]     r_eng_inp;
  logic             r_m_valid;
  logic [W-1:0]     r_m_data;
  logic             r_m_last;
  logic [CNT_W-1:0] r_frame_count;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_capture;
  logic [IDX_W-1:0] w_cap_idx;
  logic [IDX_W-1:0] w_inp_idx;

  assign w_in_hs   = s_valid & r_s_ready;
  assign w_out_hs  = r_m_valid & m_ready;
  // Engine output lags the first replayed sample by LATENCY RUN cycles.
  assign w_capture = (r_state == ST_RUN) && (r_t >= T_LAT);
  assign w_cap_idx = IDX_W'(r_t - T_LAT);
  assign w_inp_idx = IDX_W'(w_t_next);

  // Next-state and index/counter updates.
  always_comb begin
    w_next_state = r_state;
    w_wr_next    = r_wr_idx;
    w_t_next     = '0;
    w_rd_next    = r_rd_idx;
    w_frame_done = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_in_hs) begin
          if (r_wr_idx == LAST_IDX) begin
            w_wr_next    = '0;
`ifdef DCT_SCHED_CLR_EN
            w_next_state = ST_CLR;
`else
            w_next_state = ST_RUN;
`endif
          end else begin
            w_wr_next = r_wr_idx + IDX_W'(1);
          end
        end
      end
      ST_CLR: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (r_t == LAST_T) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_t_next = r_t + T_W'(1);
        end
      end
      ST_DRAIN: begin
        if (w_out_hs) begin
          if (r_rd_idx == LAST_IDX) begin
            w_rd_next    = '0;
            w_next_state = ST_LOAD;
            w_frame_done = 1'b1;
          end else begin
            w_rd_next = r_rd_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  // State, counters and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_LOAD;
      r_wr_idx      <= '0;
      r_t           <= '0;
      r_rd_idx      <= '0;
      r_s_ready     <= 1'b0;
      r_busy        <= 1'b0;
      r_eng_en      <= 1'b0;
      r_eng_inp     <= '0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_m_last      <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state   <= w_next_state;
      r_wr_idx  <= w_wr_next;
      r_t       <= w_t_next;
      r_rd_idx  <= w_rd_next;
      r_s_ready <= (w_next_state == ST_LOAD);
      r_busy    <= (w_next_state != ST_LOAD);
      r_eng_en  <= (w_next_state == ST_RUN);
      if ((w_next_state == ST_RUN) && (w_t_next < T_PTS)) begin
        r_eng_inp <= r_in_buf[w_inp_idx];
      end else begin
        r_eng_inp <= '0;
      end
      r_m_valid <= (w_next_state == ST_DRAIN);
      if (w_next_state == ST_DRAIN) begin
        r_m_data <= r_out_buf[w_rd_next];
        r_m_last <= (w_rd_next == LAST_IDX);
      end else begin
        r_m_data <= '0;
        r_m_last <= 1'b0;
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
    end
  end

  // Sample and coefficient storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (reset && w_in_hs) begin
      r_in_buf[r_wr_idx] <= s_data;
    end
    if (reset && w_capture) begin
      r_out_buf[w_cap_idx] <= eng_out;
    end
  end

`ifdef DCT_SCHED_CLR_EN
  logic r_eng_reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_eng_reset <= 1'b0;
    end else begin
      r_eng_reset <= (w_next_state == ST_CLR);
    end
  end

  // Engine is held in reset alongside the system reset and pulsed in CLR.
  assign eng_reset = r_eng_reset | ~reset;
`else
  assign eng_reset = ~reset;
`endif

  assign s_ready     = r_s_ready;
  assign busy        = r_busy;
  assign eng_en      = r_eng_en;
  assign eng_inp     = r_eng_inp;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_index     = r_rd_idx;
  assign m_last      = r_m_last;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_dct_frame_scheduler.sv
// Directed bench for dct_frame_scheduler with an echo engine stub (eng_out = eng_inp delayed LATENCY cycles).
module tb_dct_frame_scheduler;

  localparam int unsigned NPT = 16;
  localparam int unsigned LAT = 20;
  localparam int unsigned CW  = 2;
`ifdef DCT_SCHED_CLR_EN
  localparam int CLR_OFF = 1;
`else
  localparam int CLR_OFF = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          eng_en;
  logic [31:0]   eng_inp;
  logic [31:0]   eng_out;
  logic          eng_reset;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic [3:0]    m_index;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_fc;

  logic [31:0] base [16] = '{
    32'h41200000, 32'h41A00000, 32'h00000000, 32'hC0A00000,
    32'h41F00000, 32'h41400000, 32'h42040000, 32'hC0800000,
    32'h41900000, 32'h41400000, 32'hC1100000, 32'h40000000,
    32'hC0E00000, 32'h41980000, 32'h40000000, 32'h41A80000
  };
  logic [31:0] frame_d [16];
  logic [31:0] pipe [LAT];

  always #5 clk = ~clk;

  // Engine stub: pure delay line.
  always @(posedge clk) begin
    pipe[0] <= eng_inp;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign eng_out = pipe[LAT-1];

  dct_frame_scheduler #(
    .DCT_POINT(NPT), .M(23), .E(8), .LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .eng_en(eng_en), .eng_inp(eng_inp), .eng_out(eng_out), .eng_reset(eng_reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps, input bit hold_after, input logic [31:0] next0);
    for (int i = 0; i < 16; i++) begin
      int guard;
      bit hs;
      guard = 0;
      hs = 1'b0;
      while (!hs) begin
        s_valid = 1'b1;
        s_data  = frame_d[i];
        chk("load_eng_en", 32'(eng_en), 0);
        chk("load_busy", 32'(busy), 0);
        hs = s_ready;
        tick;
        guard++;
        if (guard > 50) begin
          $display("FAIL load_timeout: sample %0d never accepted", i);
          $fatal(1, "load timeout");
        end
      end
      if (gaps && i < 15) begin
        s_valid = 1'b0;
        tick;
      end
    end
    s_valid = hold_after;
    s_data  = next0;
  endtask

  task automatic run_and_drain(input bit bp);
    int cyc;
    int idx;
    bit hs;
    logic [31:0] exp_inp;
    chk("post_hs_busy", 32'(busy), 1);
`ifdef DCT_SCHED_CLR_EN
    chk("clr_eng_reset", 32'(eng_reset), 1);
    chk("clr_eng_en", 32'(eng_en), 0);
    tick;
`endif
    for (int t = 0; t < int'(LAT + NPT); t++) begin
      if (t < int'(NPT)) exp_inp = frame_d[t];
      else exp_inp = 32'h0;
      chk("run_eng_en", 32'(eng_en), 1);
      chk("run_eng_inp", eng_inp, exp_inp);
      chk("run_s_ready", 32'(s_ready), 0);
      chk("run_m_valid", 32'(m_valid), 0);
      chk("run_eng_reset", 32'(eng_reset), 0);
      tick;
    end
    chk("drain_eng_en", 32'(eng_en), 0);
    cyc = 0;
    idx = 0;
    while (idx < int'(NPT) && cyc < 100) begin
      m_ready = bp ? (cyc % 2 == 1) : 1'b1;
      chk("drain_m_valid", 32'(m_valid), 1);
      chk("drain_m_data", m_data, frame_d[idx]);
      chk("drain_m_index", 32'(m_index), 32'(idx));
      chk("drain_m_last", 32'(m_last), 32'(idx == 15));
      chk("drain_s_ready", 32'(s_ready), 0);
      hs = m_ready;
      tick;
      if (hs) idx++;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_cycles", 32'(cyc), bp ? 32 : 16);
    chk("idle_m_valid", 32'(m_valid), 0);
    chk("idle_s_ready", 32'(s_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    exp_fc = exp_fc + CW'(1);
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    m_ready = 1'b0;
    exp_fc  = '0;
    repeat (3) tick;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eng_en", 32'(eng_en), 0);
    chk("rst_eng_inp", eng_inp, 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_index", 32'(m_index), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_eng_reset", 32'(eng_reset), 1);
    reset = 1'b1;
    tick;
    chk("rel_s_ready", 32'(s_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_eng_reset", 32'(eng_reset), 0);

    // Basic frame, continuous samples
    for (int i = 0; i < 16; i++) frame_d[i] = base[i];
    send_frame(1'b0, 1'b0, 32'h0);
    run_and_drain(1'b0);

    // Backpressure, reversed data
    for (int i = 0; i < 16; i++) frame_d[i] = base[15-i];
    send_frame(1'b0, 1'b0, 32'h0);
    run_and_drain(1'b1);

    // Input gaps, then s_valid held through RUN/DRAIN with next frame's sample 0
    for (int i = 0; i < 16; i++) frame_d[i] = base[i] ^ 32'h8000_0000;
    send_frame(1'b1, 1'b1, 32'h3F80_0000);
    run_and_drain(1'b0);
    for (int i = 0; i < 16; i++) frame_d[i] = base[(i * 3) % 16] + 32'(i);
    frame_d[0] = 32'h3F80_0000;
    send_frame(1'b0, 1'b0, 32'h0);
    run_and_drain(1'b0);

    // Reset in the middle of RUN
    for (int i = 0; i < 16; i++) frame_d[i] = 32'h4000_0000 + 32'(i);
    send_frame(1'b0, 1'b0, 32'h0);
    repeat (10 + CLR_OFF) tick;
    chk("mid_eng_en", 32'(eng_en), 1);
    chk("mid_eng_inp", eng_inp, frame_d[10]);
    reset = 1'b0;
    tick;
    chk("mid_rst_eng_en", 32'(eng_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_frame_count", 32'(frame_count), 0);
    chk("mid_rst_eng_reset", 32'(eng_reset), 1);
    reset  = 1'b1;
    exp_fc = '0;
    for (int c = 0; c < 60; c++) begin
      tick;
      chk("post_rst_m_valid", 32'(m_valid), 0);
      chk("post_rst_eng_en", 32'(eng_en), 0);
      chk("post_rst_frame_count", 32'(frame_count), 0);
    end

    // Five back-to-back frames: frame_count 1,2,3,0,1
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++) frame_d[i] = base[(i + f) % 16] ^ 32'(f << 8);
      send_frame(1'b0, 1'b0, 32'h0);
      run_and_drain(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dct_frame_scheduler.md
Name: dct_frame_scheduler

Overview:
Sequences the serial DCT engine, which takes one IEEE-754 sample per enabled cycle. Collects a DCT_POINT-sample frame from an upstream valid/ready stream, replays it into the engine with `en` held high, and captures the DCT_POINT coefficients after a fixed engine latency. It then drains the coefficients downstream with valid/ready backpressure. It sits between the sample source and the DCT_Engine instance.

Parameters:
- DCT_POINT, 16, samples per frame (power of 2, >=2).
- M, 23, mantissa width; data word is M+E+1 bits.
- E, 8, exponent width.
- LATENCY, 20, RUN cycles from the first sample presented (t=0) to the first valid coefficient on eng_out; must be >=1.
- CNT_W, 16, frame_count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream ready.
- s_data  in  M+E+1  upstream sample (IEEE-754).
- eng_en  out  1  drives engine en.
- eng_inp  out  M+E+1  drives engine inp.
- eng_out  in  M+E+1  engine out.
- eng_reset  out  1  drives engine reset (active-high); see Optional Feature.
- m_valid  out  1  coefficient valid.
- m_ready  in  1  downstream ready.
- m_data  out  M+E+1  coefficient.
- m_index  out  log2(DCT_POINT)  coefficient index, 0..DCT_POINT-1.
- m_last  out  1  high with index DCT_POINT-1.
- busy  out  1  high in any state except LOAD.
- frame_count  out  CNT_W  completed frames.

Behaviour:
- Reset (reset==0 at clk edge): state=LOAD and all counters cleared.
- While reset is low: s_ready, eng_en, eng_inp, m_valid, m_data, m_index, m_last, busy and frame_count are all 0. The partial frame is discarded.
- States are LOAD -> RUN -> DRAIN -> LOAD; CLR is inserted between LOAD and RUN only with the macro.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready cycle writes in_buf[wr_idx] and increments wr_idx.
  - The handshake at wr_idx==DCT_POINT-1 moves to RUN next cycle and clears wr_idx.
  - s_valid gaps are allowed.
- RUN:
  - s_ready=0; RUN cycle counter t starts at 0.
  - eng_en and eng_inp are registered outputs: in RUN cycle t, eng_en=1, and eng_inp=in_buf[t] for t<DCT_POINT, else 0.
  - For t>=LATENCY, eng_out sampled at the end of cycle t is stored to out_buf[t-LATENCY].
  - Exit to DRAIN after t==LATENCY+DCT_POINT-1; RUN lasts exactly LATENCY+DCT_POINT cycles.
  - eng_en=0 in every other state.
- DRAIN:
  - m_valid=1 with m_data=out_buf[rd_idx] and m_index=rd_idx.
  - m_data, m_index and m_last stay stable while m_valid&!m_ready.
  - Each handshake increments rd_idx.
  - The handshake with m_last moves to LOAD and increments frame_count (wraps at 2^CNT_W-1 -> 0).
- First s_ready=1 is in the first cycle after reset releases.
- Samples offered outside LOAD are not consumed.
- Frames never overlap; coefficients are emitted in engine output order.
- eng_out is never stalled; capture timing depends only on t.

Optional Feature:
- Macro DCT_SCHED_CLR_EN.
- Defined:
  - The LOAD exit goes to CLR for exactly one cycle, with eng_reset=1 and eng_en=0, then to RUN.
  - eng_reset=1 also while reset is low; 0 otherwise.
  - RUN starts one cycle later.
- Undefined:
  - No CLR state; eng_reset = !reset.
  - The engine is cleared only by the system reset.

Test Plan:
- Basic frame:
  - Stimulus: bench engine stub echoes eng_inp delayed by LATENCY=20. After reset, send 16 continuous samples 0x41200000, 0x41A00000, 0x00000000, 0xC0A00000, 0x41F00000, 0x41400000, 0x42040000, 0xC0800000, 0x41900000, 0x41400000, 0xC1100000, 0x40000000, 0xC0E00000, 0x41980000, 0x40000000, 0x41A80000 with m_ready=1.
  - Required: eng_en high for exactly 36 cycles, with eng_inp matching the input sequence and then 0. m_data reproduces the 16 words in order with m_index 0..15 and m_last only on index 15. frame_count=1.
- Backpressure:
  - Stimulus: m_ready alternating 1,0.
  - Required: drain takes 32 cycles, m_data/m_index stable on stalled cycles, no word lost or duplicated.
- Input gaps and blocking:
  - Stimulus: s_valid high every other cycle; keep s_valid=1 during RUN/DRAIN.
  - Required: frame completes after 16 handshakes. s_ready=0 throughout RUN/DRAIN and no extra sample is consumed; the held sample becomes sample 0 of the next frame.
- Reset mid-operation:
  - Stimulus: pull reset low at RUN t=10 for one cycle.
  - Required: next cycle eng_en=0, busy=0, m_valid never asserts, frame_count unchanged. The following full frame is output correctly.
- Counter wrap:
  - Stimulus: CNT_W=2, run 5 back-to-back frames.
  - Required: frame_count sequence 1,2,3,0,1.
- Macro DCT_SCHED_CLR_EN:
  - Defined: eng_reset is high exactly one cycle, immediately after the 16th handshake and immediately before the first eng_en cycle.
  - Undefined: eng_reset equals !reset, and eng_en rises the cycle after the 16th handshake.
